// File: rtl/sw_seq_loader_if.sv
// sw_seq_loader_if: bundle of the sequence-loader load stream and serve stream.
//   valid, data_ref, data_query : load beats from the upstream producer
//   busy                        : loader is not idle
//   q_block, q_base             : static query block of the current pass and its base index
//   r_valid, r_ready, r_sym, r_pos, pass_first, pass_last : reference stream to the PE array
//   all_done                    : pulse after the final beat of the final pass
//   err                         : sticky input-overrun flag
// Modports: slave is the loader itself, master is the producer/consumer side.
interface sw_seq_loader_if #(
    parameter int PE_NUM          = 16,
    parameter int WIDTH_POS_REF   = 7,
    parameter int WIDTH_POS_QUERY = 6
);
    logic                       valid;
    logic [1:0]                 data_ref;
    logic [1:0]                 data_query;
    logic                       busy;
    logic [2*PE_NUM-1:0]        q_block;
    logic [WIDTH_POS_QUERY-1:0] q_base;
    logic                       r_valid;
    logic                       r_ready;
    logic [1:0]                 r_sym;
    logic [WIDTH_POS_REF-1:0]   r_pos;
    logic                       pass_first;
    logic                       pass_last;
    logic                       all_done;
    logic                       err;

    modport slave (
        input  valid, data_ref, data_query, r_ready,
        output busy, q_block, q_base, r_valid, r_sym, r_pos,
               pass_first, pass_last, all_done, err
    );

    modport master (
        output valid, data_ref, data_query, r_ready,
        input  busy, q_block, q_base, r_valid, r_sym, r_pos,
               pass_first, pass_last, all_done, err
    );
endinterface

// File: rtl/sw_seq_loader.sv
// sw_seq_loader: captures streamed 2-bit reference/query sequences, then serves
// them to the Smith-Waterman PE array pass by pass (static query block per pass,
// reference streamed one symbol per valid/ready beat).
//   clk   : clock
//   reset : asynchronous, active-high reset
//   bus   : sw_seq_loader_if.slave (load stream in, serve stream out, status)
// Optional: define SW_LOADER_OVF_CHK_EN to flag valid beats arriving in SERVE/DONE on err.
module sw_seq_loader #(
    parameter int LEN_REF         = 64,
    parameter int LEN_QUERY       = 48,
    parameter int PE_NUM          = 16,
    parameter int WIDTH_POS_REF   = 7,
    parameter int WIDTH_POS_QUERY = 6
) (
    input logic            clk,
    input logic            reset,
    sw_seq_loader_if.slave bus
);
    localparam int NP = LEN_QUERY / PE_NUM;
    localparam int AW = $clog2(LEN_REF);
    localparam int QB = $clog2(2 * LEN_QUERY);

    typedef enum logic [1:0] {IDLE, LOAD, SERVE, DONE} state_t;

    state_t                     state, state_n;
    logic [WIDTH_POS_REF-1:0]   ref_cnt, r_pos;
    logic [WIDTH_POS_QUERY-1:0] q_cnt;
    logic [1:0]                 p;
    logic [1:0]                 r_mem [LEN_REF];
    logic [2*LEN_QUERY-1:0]     q_mem;
    logic                       accept, ref_full, q_full, ref_fill, q_fill;
    logic                       serve, xfer, last_beat, last_pass;
    logic [QB-1:0]              q_off;

    assign accept    = bus.valid && (state == IDLE || state == LOAD);
    assign ref_full  = ref_cnt == WIDTH_POS_REF'(LEN_REF);
    assign q_full    = q_cnt == WIDTH_POS_QUERY'(LEN_QUERY);
    // Buffer is full once this edge completes, counting a beat accepted on it.
    assign ref_fill  = ref_full || (bus.valid && ref_cnt == WIDTH_POS_REF'(LEN_REF - 1));
    assign q_fill    = q_full || (bus.valid && q_cnt == WIDTH_POS_QUERY'(LEN_QUERY - 1));
    assign serve     = state == SERVE;
    assign xfer      = serve && bus.r_ready;
    assign last_beat = r_pos == WIDTH_POS_REF'(LEN_REF - 1);
    assign last_pass = p == 2'(NP - 1);
    assign q_off     = QB'(32'(p) * 2 * PE_NUM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = bus.valid ? LOAD : IDLE;
            LOAD:    state_n = (ref_fill && q_fill) ? SERVE : LOAD;
            SERVE:   state_n = (xfer && last_beat && last_pass) ? DONE : SERVE;
            default: state_n = IDLE;
        endcase
    end

    // Serve outputs are gated to zero outside SERVE so reset values hold
    // regardless of the (unreset) buffer contents.
    always_comb begin
        bus.busy       = state != IDLE;
        bus.r_valid    = serve;
        bus.all_done   = state == DONE;
        bus.r_sym      = serve ? r_mem[r_pos[AW-1:0]] : 2'b00;
        bus.q_block    = serve ? q_mem[q_off +: 2*PE_NUM] : '0;
        bus.q_base     = serve ? WIDTH_POS_QUERY'(32'(p) * PE_NUM) : '0;
        bus.r_pos      = r_pos;
        bus.pass_first = serve && r_pos == '0;
        bus.pass_last  = serve && last_beat;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ref_cnt <= '0;
            q_cnt   <= '0;
            r_pos   <= '0;
            p       <= '0;
        end else if (state == DONE) begin
            ref_cnt <= '0;
            q_cnt   <= '0;
            r_pos   <= '0;
            p       <= '0;
        end else begin
            if (accept && !ref_full) ref_cnt <= ref_cnt + 1'b1;
            if (accept && !q_full) q_cnt <= q_cnt + 1'b1;
            if (xfer) begin
                r_pos <= last_beat ? '0 : r_pos + 1'b1;
                if (last_beat) p <= last_pass ? '0 : p + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !ref_full) r_mem[ref_cnt[AW-1:0]] <= bus.data_ref;
        if (accept && !q_full) q_mem[{q_cnt[QB-2:0], 1'b0} +: 2] <= bus.data_query;
    end

`ifdef SW_LOADER_OVF_CHK_EN
    logic err_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                                  err_q <= 1'b0;
        else if (bus.valid && (state == SERVE || state == DONE)) err_q <= 1'b1;
    end
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_sw_seq_loader.sv
// tb_sw_seq_loader: self-checking bench for sw_seq_loader (full-rate load/serve,
// holes, backpressure, reset mid-serve, input overrun).
module tb_sw_seq_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sw_seq_loader_if bus ();
    sw_seq_loader dut (.clk(clk), .reset(reset), .bus(bus));

`ifdef SW_LOADER_OVF_CHK_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        int adv;
        bit rdy;
        int pos;
        int pass;
        bit valid;
        bit done;
        bit busy;
    } vec_t;
    vec_t tbl [9];

    function automatic logic [1:0] ref_sym(int i, int s);
        return 2'((i + s) % 4);
    endfunction

    function automatic logic [1:0] qry_sym(int i, int s);
        return 2'((i / 3 + s) % 4);
    endfunction

    function automatic logic [31:0] qblk(int pass, int s);
        logic [31:0] v;
        for (int k = 0; k < 16; k++) v[2*k +: 2] = qry_sym(pass * 16 + k, s);
        return v;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(int s, bit holes, output int entry);
        int n;
        n = 0;
        entry = -1;
        bus.r_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            bus.valid = 1'b1;
            bus.data_ref = ref_sym(i, s);
            bus.data_query = (i < 48) ? qry_sym(i, s) : 2'(i * 5);
            step();
            n++;
            if (bus.r_valid && entry < 0) entry = n;
            if (holes) begin
                bus.valid = 1'b0;
                bus.data_ref = 2'(i + 1);
                bus.data_query = 2'(i + 2);
                step();
                n++;
                if (bus.r_valid && entry < 0) entry = n;
            end
        end
        bus.valid = 1'b0;
    endtask

    task automatic run_table(int s);
        for (int r = 0; r < 9; r++) begin
            bus.r_ready = tbl[r].rdy;
            repeat (tbl[r].adv) step();
            check($sformatf("row%0d ctl", r),
                  {bus.r_valid, bus.all_done, bus.busy, bus.r_pos},
                  {tbl[r].valid, tbl[r].done, tbl[r].busy, 7'(tbl[r].pos)});
            if (tbl[r].valid)
                check($sformatf("row%0d data", r),
                      {bus.r_sym, bus.q_base, bus.q_block, bus.pass_first, bus.pass_last},
                      {ref_sym(tbl[r].pos, s), 6'(tbl[r].pass * 16), qblk(tbl[r].pass, s),
                       tbl[r].pos == 0, tbl[r].pos == 63});
        end
        bus.r_ready = 1'b0;
    endtask

    task automatic backpressure(int s, bit overrun);
        int pos, pass, xfers, cyc;
        bit rdy, done_seen;
        pos = 0; pass = 0; xfers = 0; cyc = 0; done_seen = 1'b0;
        while (!done_seen && cyc < 3000) begin
            check("bp stream",
                  {bus.r_valid, bus.r_pos, bus.r_sym, bus.q_base, bus.q_block,
                   bus.pass_first, bus.pass_last, bus.all_done},
                  {1'b1, 7'(pos), ref_sym(pos, s), 6'(pass * 16), qblk(pass, s),
                   pos == 0, pos == 63, 1'b0});
            rdy = 1'($urandom_range(0, 1));
            bus.r_ready = rdy;
            bus.valid = overrun && cyc >= 10 && cyc < 15;
            bus.data_ref = 2'(cyc);
            bus.data_query = 2'(cyc + 1);
            step();
            cyc++;
            if (rdy) begin
                xfers++;
                if (pos == 63) begin
                    pos = 0;
                    pass++;
                end else pos++;
            end
            if (xfers == 192) begin
                check("bp done", {bus.all_done, bus.r_valid}, {1'b1, 1'b0});
                done_seen = 1'b1;
            end
        end
        if (!done_seen) check("bp timeout", 64'(xfers), 64'd192);
        bus.valid = 1'b0;
        bus.r_ready = 1'b0;
    endtask

    initial begin
        int entry;
        tbl[0] = '{0,  1, 0,  0, 1, 0, 1};
        tbl[1] = '{1,  1, 1,  0, 1, 0, 1};
        tbl[2] = '{62, 1, 63, 0, 1, 0, 1};
        tbl[3] = '{1,  1, 0,  1, 1, 0, 1};
        tbl[4] = '{63, 1, 63, 1, 1, 0, 1};
        tbl[5] = '{1,  1, 0,  2, 1, 0, 1};
        tbl[6] = '{63, 1, 63, 2, 1, 0, 1};
        tbl[7] = '{1,  1, 0,  0, 0, 1, 1};
        tbl[8] = '{1,  0, 0,  0, 0, 0, 0};
        bus.valid = 1'b0;
        bus.data_ref = 2'b00;
        bus.data_query = 2'b00;
        bus.r_ready = 1'b0;
        step();
        step();
        check("reset outputs",
              {bus.busy, bus.r_valid, bus.pass_first, bus.pass_last, bus.all_done, bus.err,
               bus.q_block, bus.q_base, bus.r_pos, bus.r_sym},
              64'd0);
        reset = 1'b0;
        step();

        load(0, 1'b0, entry);
        check("full entry", 64'(entry), 64'd64);
        run_table(0);

        load(1, 1'b1, entry);
        check("holes entry", 64'(entry), 64'd127);
        run_table(1);

        load(2, 1'b0, entry);
        check("bp entry", 64'(entry), 64'd64);
        backpressure(2, 1'b0);
        check("err clean", 64'(bus.err), 64'd0);
        step();

        load(2, 1'b0, entry);
        bus.r_ready = 1'b1;
        repeat (84) step();
        check("mid serve pos", {bus.r_pos, bus.q_base}, {7'd20, 6'd16});
        reset = 1'b1;
        #1;
        check("async reset", {bus.busy, bus.r_valid, bus.all_done}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("in reset", {bus.busy, bus.r_valid, bus.all_done, bus.r_pos}, 64'd0);
        end
        reset = 1'b0;
        bus.r_ready = 1'b0;
        step();
        check("post reset idle", {bus.busy, bus.all_done}, 64'd0);
        load(3, 1'b0, entry);
        check("reload entry", 64'(entry), 64'd64);
        run_table(3);

        load(0, 1'b0, entry);
        backpressure(0, 1'b1);
        check("err overrun", 64'(bus.err), 64'(OVF));
        step();
        step();
        check("err sticky", {bus.err, bus.busy}, {OVF, 1'b0});
        reset = 1'b1;
        step();
        check("err cleared", 64'(bus.err), 64'd0);
        reset = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
